// File: rtl/axi_pkg.sv
// Shared AXI4 constants used by the write master and its burst calculator.
//   AXI_BURST_INCR    : AWBURST/ARBURST encoding for incrementing bursts
//   AXI_RESP_OKAY     : BRESP/RRESP encoding for a successful transfer
//   AXI_CACHE_DEFAULT : AWCACHE value (bufferable, modifiable)
//   AXI_4KB_SHIFT     : log2 of the 4 KB region no burst may cross
package axi_pkg;

    localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0]  AXI_CACHE_DEFAULT = 4'b0011;
    localparam int unsigned AXI_4KB_SHIFT     = 12;

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst sizing for an INCR burst.
//   addr_offset : byte offset of the burst start inside its 4 KB region
//   remaining   : beats still to be transferred for the command
//   burst_beats : min(remaining, MAX_BURST_LEN, beats left before the 4 KB boundary)
module axi_burst_calc
    import axi_pkg::*;
#(
    parameter int unsigned STRB_WIDTH    = 4,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter int unsigned BEATS_W       = $clog2(MAX_BURST_LEN + 1)
) (
    input  logic [AXI_4KB_SHIFT-1:0] addr_offset,
    input  logic [LEN_WIDTH-1:0]     remaining,
    output logic [BEATS_W-1:0]       burst_beats
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);

    logic [31:0] to_boundary;
    logic [31:0] limit;

    always_comb begin
        to_boundary = ((32'd1 << AXI_4KB_SHIFT) - 32'(addr_offset)) >> ADDR_LSB;
        limit       = 32'(MAX_BURST_LEN);
        if (to_boundary < limit) begin
            limit = to_boundary;
        end
        if (32'(remaining) < limit) begin
            limit = 32'(remaining);
        end
        burst_beats = BEATS_W'(limit);
    end

endmodule

// File: rtl/axi_stream_wr_master.sv
// AXI4 write master: turns (addr, beat-count) commands plus an AXI-Stream data
// source into INCR write bursts, one burst outstanding at a time, split at
// MAX_BURST_LEN beats and at 4 KB boundaries.
//   clk, rst                     : clock, asynchronous active-high reset
//   cmd_addr/len/valid/ready     : command (byte address, beat count; 0 = empty)
//   s_axis_tdata/tvalid/tready   : write data stream, passed straight to W
//   m_axi_aw*, m_axi_w*, m_axi_b*: AXI4 write address / data / response channels
//   busy                         : a non-empty command is in progress
//   done                         : one-cycle pulse when a command completes
//   err                          : sticky, set by any non-OKAY BRESP of the command
module axi_stream_wr_master
    import axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned AXI_ID        = 0,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned LEN_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int unsigned BEATS_W  = $clog2(MAX_BURST_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [BEATS_W-1:0]    burst_beats;
    logic [BEATS_W-1:0]    beat_cnt;
    logic [BEATS_W-1:0]    calc_beats;
    logic                  awvalid_r;
    logic                  cmd_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic                  cmd_fire;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  last_beat;
    logic                  last_burst;
    logic                  unused_bid;

    axi_burst_calc #(
        .STRB_WIDTH    (STRB_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .LEN_WIDTH     (LEN_WIDTH),
        .BEATS_W       (BEATS_W)
    ) u_burst_calc (
        .addr_offset (addr[AXI_4KB_SHIFT-1:0]),
        .remaining   (remaining),
        .burst_beats (calc_beats)
    );

    assign unused_bid = ^m_axi_bid;

    assign cmd_fire   = cmd_valid && cmd_ready_r;
    assign aw_fire    = awvalid_r && m_axi_awready;
    assign w_fire     = m_axi_wvalid && m_axi_wready;
    assign last_beat  = (beat_cnt == burst_beats - BEATS_W'(1));
    assign last_burst = (remaining == LEN_WIDTH'(burst_beats));

    assign cmd_ready     = cmd_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = 8'(burst_beats - BEATS_W'(1));
    assign m_axi_awsize  = 3'(ADDR_LSB);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = s_axis_tdata;
    assign m_axi_wstrb   = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stream/W/B handshakes are decoded from the registered state so that an
    // asynchronous reset removes them in the same cycle.
    always_comb begin
        state_next    = state;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        s_axis_tready = 1'b0;
        m_axi_bready  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_fire && cmd_len != '0) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (aw_fire) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                m_axi_wvalid  = s_axis_tvalid;
                s_axis_tready = m_axi_wready;
                m_axi_wlast   = last_beat;
                if (s_axis_tvalid && m_axi_wready && last_beat) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_next = last_burst ? S_IDLE : S_ADDR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            remaining   <= '0;
            burst_beats <= '0;
            beat_cnt    <= '0;
            awvalid_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            cmd_ready_r <= (state_next == S_IDLE);
            unique case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        addr      <= cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                        remaining <= cmd_len;
                        err_r     <= 1'b0;
                        busy_r    <= (cmd_len != '0);
                        done_r    <= (cmd_len == '0);
                    end
                end
                S_ADDR: begin
                    // First ADDR cycle only sizes the burst; awvalid follows
                    // one cycle later so AW fields are stable while valid.
                    if (!awvalid_r) begin
                        burst_beats <= calc_beats;
                        beat_cnt    <= '0;
                        awvalid_r   <= 1'b1;
                    end else if (m_axi_awready) begin
                        awvalid_r <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + BEATS_W'(1);
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != AXI_RESP_OKAY) begin
                            err_r <= 1'b1;
                        end
                        addr      <= addr + (ADDR_WIDTH'(burst_beats) << ADDR_LSB);
                        remaining <= remaining - LEN_WIDTH'(burst_beats);
                        if (last_burst) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_wr_master.sv
// Self-checking bench for axi_stream_wr_master: a behavioural AXI slave with
// memory, a random stream source and a burst/data reference model.
module tb_axi_stream_wr_master;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int SW  = 4;
    localparam int IW  = 8;
    localparam int MBL = 16;
    localparam int LW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [IW-1:0] m_axi_awid;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awlock;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [IW-1:0] m_axi_bid = '0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic          busy, done, err;

    always #5 clk = ~clk;

    axi_stream_wr_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
        .AXI_ID(0), .MAX_BURST_LEN(MBL), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int p_tvalid = 100;
    int p_ready = 100;

    logic [31:0] src_q[$];
    logic [31:0] exp_data[$];
    logic [23:0] exp_aw[$];     // {addr, len}
    logic [1:0]  bresp_q[$];
    logic [31:0] mem [0:16383];

    logic        t_taken = 1'b0;
    logic        b_taken = 1'b0;
    int          b_pending = 0;
    logic        aw_active = 1'b0;
    logic        resp_wait = 1'b0;
    logic        aw_hold = 1'b0;
    logic [23:0] aw_prev = '0;
    int          cur_len = 0;
    int          wbeat = 0;
    logic [15:0] w_addr = '0;
    int          aw_cnt = 0;
    int          done_cnt = 0;
    int          done_edge = 0;
    int          last_b_edge = 0;
    int          wtot = 0;
    logic        err_at_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stream source ----------------
    initial forever begin
        @(posedge clk); #1;
        if (rst) begin
            s_axis_tvalid = 1'b0;
            t_taken = 1'b0;
        end else begin
            if (t_taken) begin
                void'(src_q.pop_front());
                s_axis_tvalid = 1'b0;
                t_taken = 1'b0;
            end
            if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(99) < p_tvalid) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata = src_q[0];
            end
        end
    end

    // ---------------- AXI slave ----------------
    initial forever begin
        @(posedge clk); #1;
        m_axi_bid = 8'($urandom);
        if (rst) begin
            m_axi_awready = 1'b0;
            m_axi_wready = 1'b0;
            m_axi_bvalid = 1'b0;
            b_taken = 1'b0;
            b_pending = 0;
        end else begin
            m_axi_awready = ($urandom_range(99) < p_ready);
            m_axi_wready = ($urandom_range(99) < p_ready);
            if (b_taken) begin
                m_axi_bvalid = 1'b0;
                b_taken = 1'b0;
            end
            if (!m_axi_bvalid && b_pending > 0 && $urandom_range(99) < p_ready) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp = 2'b00;
                if (bresp_q.size() > 0) m_axi_bresp = bresp_q.pop_front();
                b_pending--;
            end
        end
    end

    // ---------------- monitor (values here hold through the next rising edge) ----------------
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("wvalid_gate", m_axi_wvalid, aw_active && s_axis_tvalid);
            check("tready_gate", s_axis_tready, aw_active && m_axi_wready);
            check("bready_gate", m_axi_bready, resp_wait);
            if (s_axis_tvalid && s_axis_tready) t_taken = 1'b1;

            if (aw_hold) begin
                check("aw_held", m_axi_awvalid, 1);
                check("aw_stable", {m_axi_awaddr, m_axi_awlen}, aw_prev);
            end
            aw_hold = m_axi_awvalid && !m_axi_awready;
            aw_prev = {m_axi_awaddr, m_axi_awlen};

            if (m_axi_wvalid && m_axi_wready) begin
                wtot++;
                check("w_after_aw", aw_active, 1);
                check("wstrb", m_axi_wstrb, 4'hf);
                if (exp_data.size() == 0) check("w_unexpected", 1, 0);
                else check("wdata", m_axi_wdata, exp_data.pop_front());
                check("wlast", m_axi_wlast, wbeat == cur_len);
                mem[w_addr[15:2]] = m_axi_wdata;
                w_addr = w_addr + 16'd4;
                wbeat++;
                if (m_axi_wlast) begin
                    aw_active = 1'b0;
                    resp_wait = 1'b1;
                    b_pending++;
                end
            end

            if (m_axi_bvalid && m_axi_bready) begin
                b_taken = 1'b1;
                resp_wait = 1'b0;
                last_b_edge = cyc + 1;
            end

            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++;
                check("aw_while_burst", aw_active || resp_wait, 0);
                if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                else check("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, exp_aw.pop_front());
                check("aw_const",
                      {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
                      {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
                aw_active = 1'b1;
                cur_len = int'(m_axi_awlen);
                wbeat = 0;
                w_addr = m_axi_awaddr;
            end

            if (done) begin
                done_cnt++;
                done_edge = cyc;
                err_at_done = err;
            end
        end
    end

    // ---------------- command runner with reference model ----------------
    task automatic run_cmd(input logic [15:0] a_in, input int len, input int err_idx);
        int a, rem, n, nb, base, hs_edge, t;
        logic [31:0] d;
        logic [31:0] dq[$];
        logic exp_err;
        a = int'(a_in) & 32'hfffc;
        base = a;
        rem = len;
        nb = 0;
        exp_err = 1'b0;
        while (rem > 0) begin
            n = min3(rem, MBL, (4096 - (a % 4096)) / 4);
            exp_aw.push_back({16'(a), 8'(n - 1)});
            bresp_q.push_back((nb == err_idx) ? 2'b10 : 2'b00);
            if (nb == err_idx) exp_err = 1'b1;
            a = (a + n * 4) % 65536;
            rem -= n;
            nb++;
        end
        for (int k = 0; k < len; k++) begin
            d = $urandom;
            dq.push_back(d);
            src_q.push_back(d);
            exp_data.push_back(d);
        end
        aw_cnt = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        cmd_addr = a_in;
        cmd_len = 16'(len);
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 100);
        hs_edge = cyc + 1;
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("busy_after_cmd", busy, len != 0);
        t = 0;
        while (done_cnt == 0 && t < 5000) begin
            @(negedge clk); #1;
            t++;
        end
        check("done_seen", done_cnt != 0, 1);
        check("done_latency", done_edge, (len == 0) ? hs_edge : last_b_edge);
        check("err_at_done", err_at_done, exp_err);
        check("aw_count", aw_cnt, nb);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_data.size(), 0);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("err_sticky", err, exp_err);
        check("busy_idle", busy, 0);
        for (int k = 0; k < len; k++)
            check("mem_readback", mem[((base + 4 * k) % 65536) / 4], dq[k]);
    endtask

    task automatic reset_mid_data();
        int t;
        p_tvalid = 100;
        p_ready = 100;
        exp_aw.push_back({16'h0300, 8'd7});
        bresp_q.push_back(2'b00);
        for (int k = 0; k < 8; k++) begin
            src_q.push_back(32'hA000_0000 + 32'(k));
            exp_data.push_back(32'hA000_0000 + 32'(k));
        end
        wtot = 0;
        @(posedge clk); #1;
        cmd_addr = 16'h0300;
        cmd_len = 16'd8;
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        t = 0;
        while (wtot < 2 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        check("reached_beat2", wtot >= 2, 1);
        rst = 1'b1;
        #1;
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_tready", s_axis_tready, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        src_q.delete();
        exp_data.delete();
        exp_aw.delete();
        bresp_q.delete();
        aw_active = 1'b0;
        resp_wait = 1'b0;
        aw_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("cmd_ready_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        check("cmd_ready_after_rst", cmd_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra;
        int rl, re;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_awvalid", m_axi_awvalid, 0);
        check("reset_wvalid", m_axi_wvalid, 0);
        check("reset_bready", m_axi_bready, 0);
        check("reset_tready", s_axis_tready, 0);
        check("reset_flags", {busy, done, err}, 3'b000);
        rst = 1'b0;
        #1;
        check("cmd_ready_pre_edge", cmd_ready, 0);
        @(posedge clk); #1;
        check("cmd_ready_first_edge", cmd_ready, 1);

        run_cmd(16'h0100, 4, -1);
        run_cmd(16'h0000, 40, -1);
        run_cmd(16'h0FF0, 8, -1);
        run_cmd(16'h0200, 40, 1);
        run_cmd(16'h0400, 0, -1);

        p_tvalid = 60;
        p_ready = 50;
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rl = (i == 5) ? 0 : int'($urandom_range(1, 50));
            re = int'($urandom_range(0, 4)) - 1;
            run_cmd(ra, rl, re);
        end
        run_cmd(16'hFFE2, 20, -1);

        reset_mid_data();
        p_tvalid = 70;
        p_ready = 70;
        run_cmd(16'h0500, 20, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
